// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: press-request handshake plus keypad matrix lines between the sequencer/scanner and the emulator.
interface keypad_emulator_if #(
    parameter int HOLD_WIDTH = 24
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_key;
    logic [HOLD_WIDTH-1:0] req_hold;
    logic [3:0]            col;
    logic [3:0]            row;
    logic                  contact;
    logic                  busy;
    logic                  done;

    modport master (
        output req_valid, req_key, req_hold, col,
        input  req_ready, row, contact, busy, done
    );

    modport slave (
        input  req_valid, req_key, req_hold, col,
        output req_ready, row, contact, busy, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: single-key 4x4 matrix keypad responder with contact bounce on press and release.
// Optional KEYEMU_RANDOM_BOUNCE_EN gates each bounce toggle with an 8-bit LFSR bit.
module keypad_emulator #(
    parameter int HOLD_WIDTH     = 24,
    parameter int BOUNCE_PERIOD  = 50000,
    parameter int BOUNCE_TOGGLES = 6,
    parameter int GAP_CYCLES     = 100000
) (
    input logic               clock,
    input logic               reset,
    keypad_emulator_if.slave  kp
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] BOUNCE_IN  = 3'd1;
    localparam logic [2:0] HOLD       = 3'd2;
    localparam logic [2:0] BOUNCE_OUT = 3'd3;
    localparam logic [2:0] GAP        = 3'd4;

    localparam int PW = BOUNCE_PERIOD > 1 ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int TW = $clog2(BOUNCE_TOGGLES + 1);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(BOUNCE_PERIOD - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(BOUNCE_TOGGLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [3:0]            key_q, key_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [PW-1:0]         per_q, per_d;
    logic [TW-1:0]         tog_q, tog_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  contact_q, contact_d;
    logic                  done_q, done_d;
    logic [3:0]            row_q, row_d;
    logic                  xfer, bouncing, per_tc, tog_en, tog_hit, tog_end;

`ifdef KEYEMU_RANDOM_BOUNCE_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign tog_en = lfsr_q[0];
`else
    assign tog_en = 1'b1;
`endif

    assign xfer     = kp.req_valid && kp.req_ready;
    assign bouncing = state_q == BOUNCE_IN || state_q == BOUNCE_OUT;
    assign per_tc   = per_q == PER_LAST;
    assign tog_hit  = bouncing && per_tc && tog_en;
    // the last toggle is replaced by the forced settled contact level
    assign tog_end  = tog_hit && tog_q == TOG_LAST;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        hold_d    = hold_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        per_d     = bouncing && !per_tc ? per_q + 1'b1 : '0;
        tog_d     = bouncing ? (tog_hit ? (tog_end ? '0 : tog_q + 1'b1) : tog_q) : '0;
        gap_d     = state_q == GAP && gap_q != GAP_LAST ? gap_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (xfer) begin
                state_d   = BOUNCE_IN;
                key_d     = kp.req_key;
                hold_d    = kp.req_hold == '0 ? HOLD_WIDTH'(1) : kp.req_hold;
                contact_d = 1'b0;
            end
            BOUNCE_IN: begin
                state_d   = tog_end ? HOLD : state_q;
                contact_d = tog_end ? 1'b1 : contact_q ^ tog_hit;
            end
            HOLD: begin
                state_d = hold_q <= HOLD_WIDTH'(1) ? BOUNCE_OUT : state_q;
                hold_d  = hold_q <= HOLD_WIDTH'(1) ? '0 : hold_q - 1'b1;
            end
            BOUNCE_OUT: begin
                state_d   = tog_end ? GAP : state_q;
                contact_d = tog_end ? 1'b0 : contact_q ^ tog_hit;
            end
            GAP: begin
                state_d = gap_q == GAP_LAST ? IDLE : state_q;
                done_d  = gap_q == GAP_LAST;
            end
            default: state_d = IDLE;
        endcase
        row_d = contact_q && !kp.col[key_q[1:0]] ? ~(4'b0001 << key_q[3:2]) : 4'hF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            key_q     <= '0;
            hold_q    <= '0;
            per_q     <= '0;
            tog_q     <= '0;
            gap_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            row_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            per_q     <= per_d;
            tog_q     <= tog_d;
            gap_q     <= gap_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            row_q     <= row_d;
        end
    end

    assign kp.req_ready = state_q == IDLE && !reset;
    assign kp.busy      = state_q != IDLE;
    assign kp.contact   = contact_q;
    assign kp.done      = done_q;
    assign kp.row       = row_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed press sequences checked cycle by cycle against the expected bounce timeline.
module tb_keypad_emulator;
    localparam int P  = 4;
    localparam int T  = 4;
    localparam int G  = 8;
    localparam int HW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    keypad_emulator_if #(.HOLD_WIDTH(HW)) kp();

    keypad_emulator #(
        .HOLD_WIDTH(HW),
        .BOUNCE_PERIOD(P),
        .BOUNCE_TOGGLES(T),
        .GAP_CYCLES(G)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp(kp.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // contact level k cycles after the transfer edge
    function automatic logic exp_contact(input int k, input int hc);
        if (k <= P * T)          return ((k - 1) / P) % 2 == 1;
        if (k <= P * T + hc)     return 1'b1;
        if (k <= 2 * P * T + hc) return ((k - 1 - P * T - hc) / P) % 2 == 0;
        return 1'b0;
    endfunction

    task automatic start(input logic [3:0] key, input logic [HW-1:0] hold);
        @(negedge clock);
        check("ready_idle", 32'(kp.req_ready), 32'd1);
        kp.req_valid = 1'b1;
        kp.req_key   = key;
        kp.req_hold  = hold;
    endtask

    task automatic follow(input int hold, input logic [3:0] row_on, input logic [1:0] c,
                          input bit rot, input bit keep, input int stop);
        int hc;
        int last;
        logic pc;
        logic ec;
        logic [3:0] pcol;
        hc   = hold == 0 ? 1 : hold;
        last = 2 * P * T + hc + G;
        pc   = 1'b0;
        pcol = kp.col;
        @(posedge clock);
        #1;
        if (keep) begin
            kp.req_key  = 4'b1001;
            kp.req_hold = 8'd3;
        end else begin
            kp.req_valid = 1'b0;
        end
        for (int k = 1; k <= last + 1 && k <= stop; k++) begin
            @(negedge clock);
            ec = exp_contact(k, hc);
            check("contact", 32'(kp.contact), 32'(ec));
            check("row", 32'(kp.row), 32'((pc && !pcol[c]) ? row_on : 4'hF));
            check("busy", 32'(kp.busy), 32'(k <= last));
            check("done", 32'(kp.done), 32'(k == last + 1));
            check("ready", 32'(kp.req_ready), 32'(k == last + 1));
            if (rot) kp.col = {kp.col[2:0], kp.col[3]};
            pc   = ec;
            pcol = kp.col;
        end
    endtask

    initial begin
        kp.req_valid = 1'b0;
        kp.req_key   = 4'h0;
        kp.req_hold  = '0;
        kp.col       = 4'hF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_row", 32'(kp.row), 32'hF);
        check("rst_ready", 32'(kp.req_ready), 32'd0);
        check("rst_busy", 32'(kp.busy), 32'd0);
        check("rst_done", 32'(kp.done), 32'd0);
        check("rst_contact", 32'(kp.contact), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("post_rst_ready", 32'(kp.req_ready), 32'd1);
        check("post_rst_row", 32'(kp.row), 32'hF);
        check("post_rst_busy", 32'(kp.busy), 32'd0);
        check("post_rst_done", 32'(kp.done), 32'd0);

        kp.col = 4'b1011;
        start(4'b0110, 8'd10);
        follow(10, 4'b1101, 2'd2, 1'b0, 1'b0, 1000);

        kp.col = 4'b1110;
        start(4'b0110, 8'd10);
        follow(10, 4'b1101, 2'd2, 1'b1, 1'b0, 1000);

        kp.col = 4'b1011;
        start(4'b0110, 8'd10);
        follow(10, 4'b1101, 2'd2, 1'b0, 1'b1, 1000);
        kp.col = 4'b1101;
        follow(3, 4'b1011, 2'd1, 1'b0, 1'b0, 1000);

        kp.col = 4'b1011;
        start(4'b0110, 8'd0);
        follow(0, 4'b1101, 2'd2, 1'b0, 1'b0, 1000);

        kp.col = 4'hF;
        start(4'b1111, 8'd1);
        follow(1, 4'b0111, 2'd3, 1'b0, 1'b0, 1000);

        kp.col = 4'b1011;
        start(4'b0110, 8'd10);
        follow(10, 4'b1101, 2'd2, 1'b0, 1'b0, 20);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_row", 32'(kp.row), 32'hF);
        check("abort_busy", 32'(kp.busy), 32'd0);
        check("abort_ready", 32'(kp.req_ready), 32'd0);
        check("abort_contact", 32'(kp.contact), 32'd0);
        check("abort_done", 32'(kp.done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        kp.col = 4'b1101;
        start(4'b0001, 8'd2);
        follow(2, 4'b1110, 2'd1, 1'b0, 1'b0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
